// File: rtl/irq_pending_latch.sv
// Interrupt pending latch ahead of the 8-to-3 priority encoder: edge capture, sticky
// pending/lost bits, software mask, and a REQ/GAP handshake. Optional IRQ_SYNC_EN adds input synchronizers.
module irq_pending_latch #(
   parameter int unsigned    NCH      = 8,
   parameter logic [NCH-1:0] MASK_RST = 8'hFF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] irq_in,
   input  logic           mask_we,
   input  logic [NCH-1:0] mask_wdata,
   input  logic           ack,
   input  logic [2:0]     ack_code,
   output logic [NCH-1:0] pend_vec,
   output logic           irq,
   output logic [NCH-1:0] pending,
   output logic [NCH-1:0] lost
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [NCH-1:0] mask;
   logic [NCH-1:0] prev;
   logic [NCH-1:0] irq_s;
   logic [NCH-1:0] edge_vec;
   logic [NCH-1:0] clr_vec;
   logic           ack_fire;

`ifdef IRQ_SYNC_EN
   logic [NCH-1:0] sync1, sync2;

   // Synchronizer resets high so lines already asserted at reset release do not trigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   assign irq_s = sync2;
`else
   assign irq_s = irq_in;
`endif

   assign edge_vec = irq_s & ~prev;
   assign pend_vec = pending & ~mask;
   assign irq      = (state == REQ);
   assign ack_fire = (state == REQ) && ack;

   // Only a channel that is actually requesting may be cleared; a stray code clears nothing.
   always_comb begin
      clr_vec = '0;
      if (ack_fire) begin
         clr_vec = pend_vec & (NCH'(1) << ack_code);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev    <= '1;
         mask    <= MASK_RST;
         pending <= '0;
         lost    <= '0;
      end else begin
         prev    <= irq_s;
         if (mask_we) begin
            mask <= mask_wdata;
         end
         // A new edge beats a same-cycle clear: pending stays set, lost starts clean.
         pending <= (pending & ~clr_vec) | edge_vec;
         lost    <= (lost & ~clr_vec) | (edge_vec & pending & ~clr_vec);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (|pend_vec) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (ack) begin
               state_next = GAP;
            end else if (!(|pend_vec)) begin
               state_next = IDLE;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch: per-cycle vector table plus hand-written reset
// and synchronizer sequences. Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_irq_pending_latch;

   logic       clk;
   logic       rst_n;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       ack;
   logic [2:0] ack_code;
   logic [7:0] pend_vec;
   logic       irq;
   logic [7:0] pending;
   logic [7:0] lost;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [7:0] irq_in;
      logic       mask_we;
      logic [7:0] mask_wdata;
      logic       ack;
      logic [2:0] ack_code;
      logic [7:0] e_pend;
      logic [7:0] e_pv;
      logic       e_irq;
      logic [7:0] e_lost;
   } vec_t;

   vec_t vecs[$];

   irq_pending_latch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ack        (ack),
      .ack_code   (ack_code),
      .pend_vec   (pend_vec),
      .irq        (irq),
      .pending    (pending),
      .lost       (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] e_pend, input logic [7:0] e_pv,
                          input logic e_irq, input logic [7:0] e_lost);
      chk({tag, " pending"}, pending, e_pend);
      chk({tag, " pend_vec"}, pend_vec, e_pv);
      chk({tag, " irq"}, {7'd0, irq}, {7'd0, e_irq});
      chk({tag, " lost"}, lost, e_lost);
   endtask

   task automatic drive(input logic [7:0] i, input logic we, input logic [7:0] wd,
                        input logic a, input logic [2:0] ac);
      irq_in     = i;
      mask_we    = we;
      mask_wdata = wd;
      ack        = a;
      ack_code   = ac;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [7:0] i, input logic we, input logic [7:0] wd,
                      input logic a, input logic [2:0] ac, input logic [7:0] ep,
                      input logic [7:0] epv, input logic ei, input logic [7:0] el);
      vec_t v;
      v.irq_in = i; v.mask_we = we; v.mask_wdata = wd; v.ack = a; v.ack_code = ac;
      v.e_pend = ep; v.e_pv = epv; v.e_irq = ei; v.e_lost = el;
      vecs.push_back(v);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; ack_code = '0;

      //    irq_in we  wdata ack code  pend   pv    irq  lost
      // reset + mask clear, single channel 5
      add(8'h00, 1, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      add(8'h20, 0, 8'h00, 0, 3'd0, 8'h20, 8'h20, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h20, 8'h20, 1, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd5, 8'h00, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      // channels 2 and 6 together, serviced with a gap between
      add(8'h44, 0, 8'h00, 0, 3'd0, 8'h44, 8'h44, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h44, 8'h44, 1, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd6, 8'h04, 8'h04, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h04, 8'h04, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h04, 8'h04, 1, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd2, 8'h00, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      // masked channel 6 latches but does not request until unmasked
      add(8'h00, 1, 8'h40, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      add(8'h40, 0, 8'h00, 0, 3'd0, 8'h40, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h40, 8'h00, 0, 8'h00);
      add(8'h00, 1, 8'h00, 0, 3'd0, 8'h40, 8'h40, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h40, 8'h40, 1, 8'h00);
      // re-masking while in REQ drops back to IDLE without an ack
      add(8'h00, 1, 8'h40, 0, 3'd0, 8'h40, 8'h00, 1, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h40, 8'h00, 0, 8'h00);
      add(8'h00, 1, 8'h00, 0, 3'd0, 8'h40, 8'h40, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h40, 8'h40, 1, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd6, 8'h00, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
      // overrun on channel 3, stray ack code, then ack colliding with a new edge
      add(8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
      add(8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h08);
      add(8'h00, 0, 8'h00, 1, 3'd1, 8'h08, 8'h08, 0, 8'h08);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 0, 8'h08);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h08);
      add(8'h08, 0, 8'h00, 1, 3'd3, 8'h08, 8'h08, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
      add(8'h00, 0, 8'h00, 1, 3'd3, 8'h00, 8'h00, 0, 8'h00);
      add(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

      // reset values while held in reset
      #3;
      chk_all("reset", 8'h00, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef IRQ_SYNC_EN
      // flush the reset-high synchronizer and edge stages, unmask all
      drive(8'h00, 1'b1, 8'h00, 1'b0, 3'd0);
      drive(8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
      drive(8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("sync idle", 8'h00, 8'h00, 1'b0, 8'h00);
      drive(8'h01, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("sync k", 8'h00, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("sync k+1", 8'h00, 8'h00, 1'b0, 8'h00);
      drive(8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("sync k+2", 8'h01, 8'h01, 1'b0, 8'h00);
      drive(8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("sync k+3", 8'h01, 8'h01, 1'b1, 8'h00);
      drive(8'h00, 1'b0, 8'h00, 1'b1, 3'd0);
      chk_all("sync ack", 8'h00, 8'h00, 1'b0, 8'h00);
`else
      foreach (vecs[i]) begin
         drive(vecs[i].irq_in, vecs[i].mask_we, vecs[i].mask_wdata, vecs[i].ack, vecs[i].ack_code);
         chk_all($sformatf("row%0d", i), vecs[i].e_pend, vecs[i].e_pv, vecs[i].e_irq, vecs[i].e_lost);
      end

      // reset in the middle of a request with channels 0 and 7 pending
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("mid pre", 8'h81, 8'h81, 1'b0, 8'h00);
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("mid req", 8'h81, 8'h81, 1'b1, 8'h00);
      #2;
      ack = 1'b1; ack_code = 3'd7;
      rst_n = 1'b0;
      #1;
      chk_all("mid rst", 8'h00, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      ack = 1'b0;
      // lines held high through release must not trigger, even once unmasked
      drive(8'h81, 1'b1, 8'h00, 1'b0, 3'd0);
      chk_all("post rst", 8'h00, 8'h00, 1'b0, 8'h00);
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("post rst2", 8'h00, 8'h00, 1'b0, 8'h00);
      // a genuine fall then rise on channel 0 is picked up again
      drive(8'h80, 1'b0, 8'h00, 1'b0, 3'd0);
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("rearm", 8'h01, 8'h01, 1'b0, 8'h00);
      drive(8'h81, 1'b0, 8'h00, 1'b0, 3'd0);
      chk_all("rearm req", 8'h01, 8'h01, 1'b1, 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Upstream stage of the 8-to-3 priority encoder. The block captures rising edges on eight raw interrupt lines into sticky pending bits and applies a software mask. It drives the masked pending vector straight into the encoder's `d` input and raises a registered request to the consumer. On acknowledge it takes back the encoder's 3-bit code and clears exactly that pending bit, with a one-cycle request gap between services.

## Interface
Parameters:
- `NCH`, 8: channel count; fixed at 8 to match the encoder width; other values unsupported.
- `MASK_RST`, 8'hFF: mask register reset value; all channels masked.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  8  raw interrupt lines; rising-edge triggered.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  8  new mask; 1 = channel masked.
- `ack`  in  1  consumer acknowledge; one-cycle pulse.
- `ack_code`  in  3  channel being acknowledged; driven from encoder output `y`.
- `pend_vec`  out  8  `pending & ~mask`; feeds encoder `d`.
- `irq`  out  1  registered service request.
- `pending`  out  8  raw pending bits, unmasked.
- `lost`  out  8  sticky per-channel overrun flags.

## Operation
- Edge detect: `prev` register per channel. An edge on channel i is `irq_in[i] & ~prev[i]` at a clock edge. `prev <= irq_in` every cycle.
- Pending set: an edge on channel i sets `pending[i]`. Masked channels still latch; the mask gates only `pend_vec`.
- Overrun: an edge on channel i while `pending[i]` is already 1 sets `lost[i]`.
- FSM states:
  - IDLE (`irq`=0): if `|pend_vec`, go to REQ.
  - REQ (`irq`=1): on `ack`, clear `pending[ack_code]` and `lost[ack_code]`, then go to GAP. If `pend_vec` becomes 0 with no ack (for example after a mask write), return to IDLE.
  - GAP (`irq`=0): one cycle, then go to IDLE unconditionally.
- `ack` outside REQ is ignored. `ack` in REQ whose `ack_code` bit is not set in `pend_vec` changes no bits but still goes to GAP.
- Simultaneous edge and ack-clear on the same channel: set wins. `pending` stays 1 and `lost` is cleared, not set.
- Mask write: the mask updates on the write edge, and `pend_vec` reflects it the next cycle. A write in the same cycle as an ack uses the old mask for that cycle's decision.
- `pend_vec` is combinational from the `pending` and `mask` registers. The encoder output is valid while `irq`=1.

## Timing
- Reset values (async, immediate): `pending`=0, `lost`=0, `mask`=`MASK_RST`, `prev`=8'hFF, state IDLE, `irq`=0.
  - Lines already high at reset release need a fall then a rise to trigger.
- Edge sampled at edge k:
  - `pending`/`pend_vec` updated after edge k.
  - State goes to REQ at edge k+1, so `irq`=1 from k+1.
  - Request latency: 2 cycles from the sampled edge, without sync.
- `ack` sampled at edge m in REQ:
  - Pending bit clears after m.
  - `irq`=0 for cycle m..m+1 (GAP).
  - If further channels are pending, `irq` reasserts at m+2.
- Reset mid-operation clears everything, including a pending `ack`. No partial state survives.

## Configuration
- `IRQ_SYNC_EN` defined: each `irq_in` bit passes through a 2-flop synchronizer (reset 1s) before edge detection. Request latency becomes 4 cycles, and a line must be stable high for at least 1 clock to register.
- `IRQ_SYNC_EN` undefined: `irq_in` feeds edge detection directly. The lines must already be synchronous to `clk`.

## Test plan
- **Reset and mask:** reset, write mask 8'h00, pulse `irq_in[5]` -> `pending`=8'h20, `pend_vec`=8'h20, `irq`=1 two cycles after the sampled edge.
- **Multi-channel service:** pulse channels 2 and 6 together, ack with 3'b110 -> `pending`=8'h04, `irq` low one cycle; then ack 3'b010 -> `pending`=0, `irq` stays 0.
- **Masking:** mask 8'h40, pulse channel 6 -> `pending`=8'h40, `pend_vec`=0, `irq`=0; write mask 8'h00 -> `irq`=1 two cycles after the write.
- **Overrun and collision:** second rising edge on channel 3 before ack -> `lost`=8'h08. Ack 3'b011 in the same cycle as a new channel-3 edge -> `pending[3]`=1, `lost[3]`=0.
- **Reset mid-request:** assert `rst_n`=0 while `irq`=1 with `pending`=8'h81 -> all outputs return to their reset values immediately. Lines still high after release cause no new request.
- **`IRQ_SYNC_EN` build:** one-cycle-wide pulse on channel 0 -> `pending[0]` sets 2 cycles later than in the unsynced build, and `irq` rises 4 cycles after the pulse.
